cpl_resp_arbiter: RTL and testbench
===================================

# cpl_resp_arbiter

Weighted round-robin scheduler that shares the completion generator between the R-channel (read completion with data) and B-channel (write completion without data) response-info FIFOs of the AXI–PCIe master bridge. It drives the channel-select input of the AXI-to-PCIe completion mapping logic. It locks the selection for the full life of each completion and steers the generator's consume pulse back to the FIFO that was served. It replaces the fixed R-over-B priority with bounded, starvation-free sharing.

## Interface
Parameters:
- `R_WEIGHT`, default 4: maximum consecutive R completions while B is pending.
- `B_WEIGHT`, default 1: maximum consecutive B completions while R is pending.
- `CNT_WIDTH`, default 3: width of the burst counter; must satisfy 2^CNT_WIDTH ≥ max(R_WEIGHT, B_WEIGHT).

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: reset, synchronous and active-high.
- `i_RVALID_fifo`, in, 1: R response-info FIFO is non-empty.
- `i_BVALID_fifo`, in, 1: B response FIFO is non-empty.
- `i_cpl_info_inc`, in, 1: single-cycle pulse from the completion generator meaning the current completion info has been consumed.
- `o_channel_sel`, out, 1: mapping-logic select; 0 = READ_RESP, 1 = WRITE_RESP.
- `o_cpl_valid`, out, 1: the selected FIFO is granted and valid.
- `o_r_ch_read_info_inc`, out, 1: pop pulse to the R FIFO.
- `o_b_ch_read_inc`, out, 1: pop pulse to the B FIFO.
- `o_grant_r`, out, 1: state is GNT_R.
- `o_grant_b`, out, 1: state is GNT_B.
- `o_protocol_err`, out, 1: sticky flag for a spurious consume pulse.

## Operation
States:
- IDLE: no grant.
- GNT_R: R granted.
- GNT_B: B granted.

Registered state:
- state;
- `burst_cnt[CNT_WIDTH-1:0]`;
- `last_served`, 1 bit;
- `o_channel_sel`;
- `o_protocol_err`.

IDLE transitions:
- Only R valid → GNT_R.
- Only B valid → GNT_B.
- Both valid → grant the channel that is not `last_served`.
- Neither valid → stay in IDLE.
- `burst_cnt` is cleared on entry to either grant state.

GNT_X without a pulse (X = granted channel, Y = the other channel):
- X valid → hold state; the grant never changes mid-completion.
- X invalid, Y valid → GNT_Y, `burst_cnt` = 0.
- Neither valid → IDLE.

GNT_X when `i_cpl_info_inc`=1 and X valid:
- Pulse the X pop output in the same cycle, combinationally.
- `last_served` ← X.
- `burst_cnt`+1 < WEIGHT_X → stay in GNT_X, `burst_cnt`++.
- `burst_cnt`+1 = WEIGHT_X and Y valid → GNT_Y directly, with no IDLE bubble; `burst_cnt` = 0.
- `burst_cnt`+1 = WEIGHT_X and Y invalid → stay in GNT_X, `burst_cnt` = 0.

Spurious pulse:
- Condition: `i_cpl_info_inc` while in IDLE, or while the granted FIFO's valid is low.
- Both pop outputs stay 0.
- `o_protocol_err` ← 1; it is cleared only by reset.

Outputs:
- `o_cpl_valid` = (GNT_R & `i_RVALID_fifo`) | (GNT_B & `i_BVALID_fifo`).
- `o_channel_sel` is written on entry to GNT_R (0) or GNT_B (1) and holds its value in IDLE.
- The pop outputs are never both 1 and are never asserted outside a grant.

## Timing
Reset values:
- state = IDLE, `burst_cnt` = 0.
- `last_served` = WRITE_RESP, so R wins the first tie.
- `o_channel_sel` = 0, `o_protocol_err` = 0.
- All other outputs are 0 because they decode from state.

Reset applied mid-grant: the design returns to IDLE on the next edge and no pop is issued in that cycle.

Latency and throughput:
- FIFO valid rising in IDLE at cycle N → grant and `o_cpl_valid` at cycle N+1.
- Consume-to-pop: 0 cycles.
- Back-to-back switch on weight expiry: the new grant appears the cycle after the pulse.
- One completion per cycle is sustainable within a grant.

Because the state and select are registered, `o_channel_sel` is stable for the whole cycle before the generator samples the mapped fields.

The FIFO valid seen in the pulse cycle is pre-pop. An emptied FIFO is therefore detected in the following cycle, as the "X invalid" branch above.

Every branch listed under Operation is exhaustive; no other transition exists.

## Structure
The shared bridge package holds:
- READ_RESP / WRITE_RESP encodings, common with the mapping logic;
- the state encoding (IDLE = 2'b00, GNT_R = 2'b01, GNT_B = 2'b10).

The block is a single flat module with no sub-module. It has one sequential process for state, counter and flags, and combinational decode for the outputs.

## Test plan
- **Reset and first tie:** reset, then R and B valid in the same cycle → GNT_R next cycle; `o_channel_sel`=0; `o_cpl_valid`=1.
- **Weighted sharing:** both FIFOs hold 10 entries, generator pulses every cycle with the defaults → pops follow the repeating pattern RRRRB; B is never starved.
- **Lone channel:** only B valid with 3 entries → 3 B pops with no switch; when B empties → IDLE; `o_cpl_valid`=0.
- **Grant lock:** B becomes valid while GNT_R waits 5 cycles with no pulse → grant stays R and `o_channel_sel` stays 0 until the pulse.
- **Spurious pulse:** a pulse in IDLE → no pop, and `o_protocol_err`=1 until `i_rst`.
- **Mid-operation reset:** reset asserted in GNT_B at the same time as a pulse → no pop; next cycle is IDLE with the reset values.

Source files
------------

// File: rtl/cpl_resp_arbiter_pkg.sv
// Shared bridge encodings: completion channel select and arbiter state codes.
// The select encoding is common with the AXI-to-PCIe completion mapping logic.
package cpl_resp_arbiter_pkg;

    localparam logic READ_RESP  = 1'b0;
    localparam logic WRITE_RESP = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GNT_R = 2'b01;
    localparam logic [1:0] ST_GNT_B = 2'b10;

endpackage

// File: rtl/cpl_resp_arbiter.sv
// Weighted round-robin share of the completion generator between the R and B
// response-info FIFOs; grant is locked for the life of each completion.
module cpl_resp_arbiter
    import cpl_resp_arbiter_pkg::*;
#(
    parameter int R_WEIGHT  = 4,
    parameter int B_WEIGHT  = 1,
    parameter int CNT_WIDTH = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_RVALID_fifo,
    input  logic i_BVALID_fifo,
    input  logic i_cpl_info_inc,
    output logic o_channel_sel,
    output logic o_cpl_valid,
    output logic o_r_ch_read_info_inc,
    output logic o_b_ch_read_inc,
    output logic o_grant_r,
    output logic o_grant_b,
    output logic o_protocol_err
);

    // One extra bit so burst_cnt+1 can reach a weight of 2^CNT_WIDTH.
    localparam logic [CNT_WIDTH:0] W_R = (CNT_WIDTH+1)'(R_WEIGHT);
    localparam logic [CNT_WIDTH:0] W_B = (CNT_WIDTH+1)'(B_WEIGHT);

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_burst_cnt;
    logic                 r_last_served;
    logic                 r_channel_sel;
    logic                 r_protocol_err;

    logic                 w_gnt_r;
    logic                 w_gnt_b;
    logic                 w_x_valid;
    logic                 w_y_valid;
    logic                 w_consume;
    logic                 w_x_ch;
    logic                 w_y_ch;
    logic [1:0]           w_y_state;
    logic [CNT_WIDTH:0]   w_cnt_inc;
    logic [CNT_WIDTH:0]   w_weight;
    logic                 w_expired;

    assign w_gnt_r   = (r_state == ST_GNT_R);
    assign w_gnt_b   = (r_state == ST_GNT_B);
    assign w_x_valid = (w_gnt_r & i_RVALID_fifo) | (w_gnt_b & i_BVALID_fifo);
    assign w_y_valid = w_gnt_r ? i_BVALID_fifo : i_RVALID_fifo;
    assign w_consume = i_cpl_info_inc & w_x_valid;
    assign w_x_ch    = w_gnt_b ? WRITE_RESP : READ_RESP;
    assign w_y_ch    = w_gnt_r ? WRITE_RESP : READ_RESP;
    assign w_y_state = w_gnt_r ? ST_GNT_B : ST_GNT_R;
    assign w_cnt_inc = {1'b0, r_burst_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_weight  = w_gnt_r ? W_R : W_B;
    assign w_expired = (w_cnt_inc >= w_weight);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_burst_cnt    <= '0;
            r_last_served  <= WRITE_RESP;
            r_channel_sel  <= READ_RESP;
            r_protocol_err <= 1'b0;
        end else begin
            if (i_cpl_info_inc && !w_consume) begin
                r_protocol_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_RVALID_fifo && (!i_BVALID_fifo || r_last_served == WRITE_RESP)) begin
                        r_state       <= ST_GNT_R;
                        r_burst_cnt   <= '0;
                        r_channel_sel <= READ_RESP;
                    end else if (i_BVALID_fifo) begin
                        r_state       <= ST_GNT_B;
                        r_burst_cnt   <= '0;
                        r_channel_sel <= WRITE_RESP;
                    end
                end
                ST_GNT_R, ST_GNT_B: begin
                    if (w_consume) begin
                        r_last_served <= w_x_ch;
                        if (!w_expired) begin
                            r_burst_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
                        end else begin
                            // Weight spent: hand over directly if the other side waits.
                            r_burst_cnt <= '0;
                            if (w_y_valid) begin
                                r_state       <= w_y_state;
                                r_channel_sel <= w_y_ch;
                            end
                        end
                    end else if (!w_x_valid) begin
                        if (w_y_valid) begin
                            r_state       <= w_y_state;
                            r_burst_cnt   <= '0;
                            r_channel_sel <= w_y_ch;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_grant_r            = w_gnt_r;
    assign o_grant_b            = w_gnt_b;
    assign o_cpl_valid          = w_x_valid;
    assign o_channel_sel        = r_channel_sel;
    assign o_protocol_err       = r_protocol_err;
    // Pops are suppressed in a reset cycle so nothing is lost from the FIFOs.
    assign o_r_ch_read_info_inc = w_gnt_r & w_consume & ~i_rst;
    assign o_b_ch_read_inc      = w_gnt_b & w_consume & ~i_rst;

endmodule

// File: tb/tb_cpl_resp_arbiter.sv
// Self-checking bench for cpl_resp_arbiter: directed scenarios plus a random
// run, all compared against a run-length scheduling model kept in the bench.
module tb_cpl_resp_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rv  = 1'b0;
    logic bv  = 1'b0;
    logic inc = 1'b0;

    logic o_channel_sel, o_cpl_valid, o_r_ch_read_info_inc, o_b_ch_read_inc;
    logic o_grant_r, o_grant_b, o_protocol_err;
    logic [6:0] obs;

    int total = 0;
    int bad   = 0;

    // Model: m_g = 0 none, 1 R, 2 B; m_run = completions in the current grant.
    int   m_g;
    int   m_run;
    int   m_last;
    logic m_sel;
    logic m_err;

    always #5 clk = ~clk;

    cpl_resp_arbiter dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_RVALID_fifo        (rv),
        .i_BVALID_fifo        (bv),
        .i_cpl_info_inc       (inc),
        .o_channel_sel        (o_channel_sel),
        .o_cpl_valid          (o_cpl_valid),
        .o_r_ch_read_info_inc (o_r_ch_read_info_inc),
        .o_b_ch_read_inc      (o_b_ch_read_inc),
        .o_grant_r            (o_grant_r),
        .o_grant_b            (o_grant_b),
        .o_protocol_err       (o_protocol_err)
    );

    assign obs = {o_r_ch_read_info_inc, o_b_ch_read_inc, o_grant_r, o_grant_b,
                  o_cpl_valid, o_channel_sel, o_protocol_err};

    function automatic int weight(input int ch);
        return (ch == 0) ? 4 : 1;
    endfunction

    // Expected {pop_r, pop_b, grant_r, grant_b, cpl_valid, sel, err} this cycle.
    function automatic logic [6:0] model_expect(input logic a_rv, a_bv, a_inc, a_rst);
        logic cv, pr, pb;
        cv = (m_g == 1 && a_rv) || (m_g == 2 && a_bv);
        pr = (m_g == 1) && a_inc && a_rv && !a_rst;
        pb = (m_g == 2) && a_inc && a_bv && !a_rst;
        return {pr, pb, logic'(m_g == 1), logic'(m_g == 2), cv, m_sel, m_err};
    endfunction

    task automatic start_grant(input int ch);
        m_g   = ch + 1;
        m_run = 0;
        m_sel = logic'(ch);
    endtask

    task automatic model_advance(input logic a_rv, a_bv, a_inc, a_rst);
        logic [1:0] v;
        int x, y;
        v = {a_bv, a_rv};
        if (a_rst) begin
            m_g = 0; m_run = 0; m_last = 1; m_sel = 1'b0; m_err = 1'b0;
        end else if (m_g == 0) begin
            if (a_inc) m_err = 1'b1;
            if (v[0] && v[1]) start_grant((m_last == 1) ? 0 : 1);
            else if (v[0])    start_grant(0);
            else if (v[1])    start_grant(1);
        end else begin
            x = m_g - 1;
            y = 1 - x;
            if (a_inc && v[x]) begin
                m_last = x;
                m_run++;
                if (m_run >= weight(x)) begin
                    m_run = 0;
                    if (v[y]) start_grant(y);
                end
            end else begin
                if (a_inc) m_err = 1'b1;
                if (!v[x]) begin
                    if (v[y]) start_grant(y);
                    else      m_g = 0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, return the model's expectation, advance the model.
    task automatic step(input logic a_rv, a_bv, a_inc, a_rst, output logic [6:0] e);
        @(posedge clk);
        #1;
        rv = a_rv; bv = a_bv; inc = a_inc; rst = a_rst;
        #2;
        e = model_expect(a_rv, a_bv, a_inc, a_rst);
        model_advance(a_rv, a_bv, a_inc, a_rst);
    endtask

    task automatic test_reset;
        logic [6:0] e;
        step(1'b0, 1'b0, 1'b0, 1'b1, e);
        step(1'b0, 1'b0, 1'b0, 1'b0, e);
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b", obs, 7'b0);
        end
    endtask

    task automatic test_first_tie;
        logic [6:0] e;
        step(1'b1, 1'b1, 1'b0, 1'b0, e);
        step(1'b1, 1'b1, 1'b0, 1'b0, e);
        total++;
        if ({o_grant_r, o_grant_b, o_cpl_valid, o_channel_sel} !== 4'b1010) begin
            bad++;
            $display("FAIL first_tie got gr/gb/cv/sel=%b want=1010",
                     {o_grant_r, o_grant_b, o_cpl_valid, o_channel_sel});
        end
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL first_tie_model got=%b want=%b", obs, e);
        end
    endtask

    task automatic test_weighted;
        logic [6:0] e;
        int cr, cb, idx, cyc;
        logic p;
        step(1'b0, 1'b0, 1'b0, 1'b1, e);
        cr = 10; cb = 10; idx = 0; cyc = 0;
        while ((cr > 0 || cb > 0) && cyc < 80) begin
            e = model_expect(cr > 0, cb > 0, 1'b0, 1'b0);
            p = e[2];
            step(cr > 0, cb > 0, p, 1'b0, e);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL weighted_cycle%0d got=%b want=%b", cyc, obs, e);
            end
            if (e[6] || e[5]) begin
                $display("weighted pop %0d: %s", idx, e[6] ? "R" : "B");
                if (idx < 12) begin
                    total++;
                    if (o_r_ch_read_info_inc !== logic'(idx % 5 != 4)) begin
                        bad++;
                        $display("FAIL weighted_pattern pop%0d got_r=%b want_r=%b",
                                 idx, o_r_ch_read_info_inc, logic'(idx % 5 != 4));
                    end
                end
                if (e[6]) cr--;
                if (e[5]) cb--;
                idx++;
            end
            cyc++;
        end
        total++;
        if (cr != 0 || cb != 0) begin
            bad++;
            $display("FAIL weighted_drain got r_left=%0d b_left=%0d want 0 0", cr, cb);
        end
    endtask

    task automatic test_lone;
        logic [6:0] e;
        int cb, nb;
        logic saw_r;
        step(1'b0, 1'b0, 1'b0, 1'b1, e);
        cb = 3; nb = 0; saw_r = 1'b0;
        for (int i = 0; i < 10; i++) begin
            e = model_expect(1'b0, cb > 0, 1'b0, 1'b0);
            step(1'b0, cb > 0, e[2], 1'b0, e);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL lone_cycle%0d got=%b want=%b", i, obs, e);
            end
            if (o_grant_r || o_r_ch_read_info_inc) saw_r = 1'b1;
            if (o_b_ch_read_inc) nb++;
            if (e[5]) begin
                $display("lone pop B, %0d left", cb - 1);
                cb--;
            end
        end
        total++;
        if (nb != 3 || saw_r) begin
            bad++;
            $display("FAIL lone_count got b_pops=%0d r_seen=%b want 3 0", nb, saw_r);
        end
        total++;
        if ({o_grant_b, o_cpl_valid} !== 2'b00) begin
            bad++;
            $display("FAIL lone_idle got gb/cv=%b want=00", {o_grant_b, o_cpl_valid});
        end
    endtask

    task automatic test_grant_lock;
        logic [6:0] e;
        step(1'b0, 1'b0, 1'b0, 1'b1, e);
        step(1'b1, 1'b0, 1'b0, 1'b0, e);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, e);
            total++;
            if ({o_grant_r, o_grant_b, o_channel_sel} !== 3'b100) begin
                bad++;
                $display("FAIL grant_lock_wait%0d got gr/gb/sel=%b want=100",
                         i, {o_grant_r, o_grant_b, o_channel_sel});
            end
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, e);
        total++;
        if ({o_r_ch_read_info_inc, o_b_ch_read_inc} !== 2'b10) begin
            bad++;
            $display("FAIL grant_lock_pop got pr/pb=%b want=10",
                     {o_r_ch_read_info_inc, o_b_ch_read_inc});
        end
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL grant_lock_model got=%b want=%b", obs, e);
        end
    endtask

    task automatic test_spurious;
        logic [6:0] e;
        step(1'b0, 1'b0, 1'b0, 1'b1, e);
        step(1'b0, 1'b0, 1'b1, 1'b0, e);
        total++;
        if ({o_r_ch_read_info_inc, o_b_ch_read_inc, o_protocol_err} !== 3'b000) begin
            bad++;
            $display("FAIL spurious_nopop got pr/pb/err=%b want=000",
                     {o_r_ch_read_info_inc, o_b_ch_read_inc, o_protocol_err});
        end
        for (int i = 0; i < 3; i++) begin
            step(i == 1, 1'b0, 1'b0, 1'b0, e);
            total++;
            if (o_protocol_err !== 1'b1) begin
                bad++;
                $display("FAIL spurious_sticky%0d got err=%b want=1", i, o_protocol_err);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, e);
        step(1'b0, 1'b0, 1'b0, 1'b0, e);
        total++;
        if (o_protocol_err !== 1'b0) begin
            bad++;
            $display("FAIL spurious_clear got err=%b want=0", o_protocol_err);
        end
    endtask

    task automatic test_mid_reset;
        logic [6:0] e;
        step(1'b0, 1'b0, 1'b0, 1'b1, e);
        step(1'b0, 1'b1, 1'b0, 1'b0, e);
        step(1'b0, 1'b1, 1'b0, 1'b0, e);
        total++;
        if ({o_grant_b, o_channel_sel} !== 2'b11) begin
            bad++;
            $display("FAIL mid_reset_setup got gb/sel=%b want=11", {o_grant_b, o_channel_sel});
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, e);
        total++;
        if ({o_r_ch_read_info_inc, o_b_ch_read_inc} !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset_nopop got pr/pb=%b want=00",
                     {o_r_ch_read_info_inc, o_b_ch_read_inc});
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, e);
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL mid_reset_idle got=%b want=%b", obs, 7'b0);
        end
    endtask

    task automatic test_random;
        logic [6:0] e;
        int cr, cb;
        logic r, p;
        step(1'b0, 1'b0, 1'b0, 1'b1, e);
        cr = 0; cb = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && cr < 8) cr++;
            if ($urandom_range(0, 3) == 0 && cb < 8) cb++;
            r = ($urandom_range(0, 99) == 0);
            e = model_expect(cr > 0, cb > 0, 1'b0, r);
            p = e[2] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) == 0);
            step(cr > 0, cb > 0, p, r, e);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL random_cycle%0d got=%b want=%b", i, obs, e);
            end
            if (e[6]) cr--;
            if (e[5]) cb--;
        end
    endtask

    initial begin
        m_g = 0; m_run = 0; m_last = 1; m_sel = 1'b0; m_err = 1'b0;
        test_reset();
        test_first_tie();
        test_weighted();
        test_lone();
        test_grant_lock();
        test_spurious();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
